qbus_arbiter: RTL and testbench
===============================

Name: qbus_arbiter

Overview:
- Bus-mastership controller for the 1801VM1 soft CPU's MPI/Q-bus.
- Sequences the DMA request/grant handshake (DMR -> DMGO -> SACK) between the CPU bus interface and one external DMA master.
- Stalls the CPU's bus interface while the DMA master owns the bus.
- Runs a no-reply watchdog that raises a bus error against whichever master holds SYNC.
- Sits beside the CPU bus-cycle generator in the vm1 top level.

Parameters:
- BUS_TIMEOUT, 63, ce ticks SYNC may stay high without RPLY before a bus error is flagged.
- OFFER_TIMEOUT, 15, ce ticks DMGO stays asserted awaiting SACK before the offer is withdrawn.
- CPU_GAP, 2, ce ticks after DMA release during which a new DMR is ignored, guaranteeing the CPU a bus window.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- ce  in  1  clock enable; all state advances only when ce=1
- cpu_sync  in  1  CPU is driving SYNC (bus cycle active)
- bus_rply  in  1  RPLY from the addressed slave
- dmr_i  in  1  DMA request
- sack_i  in  1  DMA master's selection acknowledge (bus held by DMA)
- dma_sync  in  1  DMA master is driving SYNC
- dmgo_o  out  1  DMA grant offer
- cpu_hold_o  out  1  CPU bus interface must not start a new cycle
- dma_owner_o  out  1  DMA master currently owns the bus
- cpu_err_o  out  1  one-ce-tick pulse: CPU cycle timed out
- dma_err_o  out  1  one-ce-tick pulse: DMA cycle timed out
- state_o  out  3  current FSM state, for debug/test bus

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - FSM in S_CPU.
  - All outputs 0.
  - Watchdog counter 0; gap counter 0.
- Reset mid-operation: DMGO and hold drop immediately (asynchronously).
- FSM states and transitions (evaluated on clk edges with ce=1):
  - S_CPU (0): cpu_hold_o=0. If dmr_i=1 and gap counter=0:
    - go to S_DRAIN if cpu_sync=1;
    - otherwise go directly to S_OFFER.
  - S_DRAIN (1): cpu_hold_o=1, so the CPU starts no new cycle. Wait for cpu_sync=0, then go to S_OFFER. If dmr_i drops first, return to S_CPU.
  - S_OFFER (2): cpu_hold_o=1, dmgo_o=1, offer counter counts ce ticks.
    - sack_i=1: go to S_DMA, dmgo_o=0 next tick.
    - dmr_i=0, or counter reaches OFFER_TIMEOUT: go to S_CPU, gap counter loaded with CPU_GAP.
  - S_DMA (3): cpu_hold_o=1, dma_owner_o=1. Stay while sack_i=1. On sack_i=0:
    - go to S_RELEASE.
    - if dma_sync is still 1 at that point, stay in S_DMA until it drops.
  - S_RELEASE (4): cpu_hold_o=0, load gap counter with CPU_GAP, go to S_CPU in one tick.
- Gap counter:
  - Decrements by one per ce tick while nonzero.
  - DMR arbitration is suppressed while it is nonzero.
  - CPU_GAP=0 disables the gap.
- Simultaneous events:
  - S_OFFER: sack_i and offer timeout in the same tick -> sack_i wins (go to S_DMA).
  - S_CPU: dmr_i=1 and cpu_sync rising in the same tick -> go to S_DRAIN; the CPU cycle completes first.
- Latency: in S_CPU with idle bus, dmr_i rises -> dmgo_o=1 on the next ce tick.
- Watchdog:
  - Monitored SYNC = cpu_sync when not dma_owner_o, else dma_sync.
  - Counter increments per ce tick while monitored SYNC=1 and bus_rply=0.
  - Counter clears when SYNC=0 or bus_rply=1.
  - On reaching BUS_TIMEOUT, pulse cpu_err_o or dma_err_o (by owner) for exactly one ce tick.
  - Counter then saturates; no further pulses until SYNC drops.
  - Counter width is ceil(log2(BUS_TIMEOUT+1)); no wrap-around.
- Unexpected sack_i in S_CPU with no offer outstanding: ignored, no state change.

Decomposition:
- Shared package vm1_bus_pkg holds:
  - state encodings S_CPU..S_RELEASE (3-bit);
  - default timeout constants, shared with the CPU bus interface.
- One sub-module, bus_watchdog:
  - inputs: sync, rply, ce;
  - outputs: timeout pulse;
  - parameter: BUS_TIMEOUT.
- qbus_arbiter routes the watchdog pulse to cpu_err_o or dma_err_o.

Test Plan:
1. Idle bus, dmr_i=1 -> dmgo_o=1 on 1st ce tick. Then sack_i=1 -> dma_owner_o=1, dmgo_o=0 next tick. Then sack_i=0 -> S_RELEASE, then S_CPU; DMR ignored for 2 ticks.
2. cpu_sync=1 for 5 ticks, dmr_i raised on tick 1 -> S_DRAIN, cpu_hold_o=1, dmgo_o=0 until cpu_sync falls; dmgo_o=1 on the following tick.
3. dmr_i held, sack_i never asserted -> dmgo_o high exactly 15 ticks, then state returns to 0, cpu_hold_o=0, gap of 2 ticks, then re-offer.
4. cpu_sync=1 with bus_rply=0 -> cpu_err_o single pulse at tick 63, no second pulse while SYNC stays high. Repeat under DMA ownership -> dma_err_o pulses instead.
5. Assert reset_n=0 while in S_DMA with dma_sync=1 -> all outputs 0 immediately, state_o=0.
6. sack_i=1 and offer timeout in the same tick -> S_DMA entered, no gap load.

Source files
------------

// File: rtl/vm1_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vm1_bus_pkg
// Purpose  : Shared definitions for the 1801VM1 MPI/Q-bus mastership logic:
//            arbiter state encodings, default bus timeouts, and a counter
//            width helper.
// Revision : 1.0 - initial release
// ============================================================================
package vm1_bus_pkg;

  // Arbiter states; encodings are visible on the debug/test bus.
  typedef enum logic [2:0] {
    S_CPU     = 3'd0,
    S_DRAIN   = 3'd1,
    S_OFFER   = 3'd2,
    S_DMA     = 3'd3,
    S_RELEASE = 3'd4
  } bus_state_t;

  // Default timing, shared with the CPU bus interface (units: ce ticks).
  localparam int unsigned C_BUS_TIMEOUT_DEF   = 63;
  localparam int unsigned C_OFFER_TIMEOUT_DEF = 15;
  localparam int unsigned C_CPU_GAP_DEF       = 2;

  // Bits needed to hold 0..max_val; never less than one bit so that a
  // zero-valued parameter still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : bus_watchdog
// Purpose  : No-reply watchdog. Counts ce ticks while SYNC is high without
//            RPLY and emits a single one-ce-tick pulse when the count
//            reaches BUS_TIMEOUT. The count then saturates until SYNC drops
//            or RPLY arrives.
// Revision : 1.0 - initial release
// ============================================================================
module bus_watchdog #(
  parameter int unsigned BUS_TIMEOUT = vm1_bus_pkg::C_BUS_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic sync,
  input  logic rply,
  output logic timeout
);

  import vm1_bus_pkg::*;

  localparam int unsigned CW = cnt_width(BUS_TIMEOUT);
  localparam logic [CW-1:0] C_LIMIT = CW'(BUS_TIMEOUT);
  localparam logic [CW-1:0] C_PRE   = CW'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // Stall counter with saturation; pulse is raised on the tick the count lands on the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (ce) begin
      r_pulse <= 1'b0;
      if (!sync || rply) begin
        r_cnt <= '0;
      end else if (r_cnt != C_LIMIT) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == C_PRE) begin
          r_pulse <= 1'b1;
        end
      end
    end
  end

  assign timeout = r_pulse;

endmodule
`default_nettype wire

// File: rtl/qbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qbus_arbiter
// Purpose  : Q-bus mastership controller. Runs the DMR -> DMGO -> SACK
//            handshake with one external DMA master, holds off the CPU bus
//            interface while DMA owns the bus, guarantees the CPU a short
//            window after each DMA tenure, and routes the no-reply watchdog
//            error to whichever master holds SYNC.
// Revision : 1.0 - initial release
// ============================================================================
module qbus_arbiter #(
  parameter int unsigned BUS_TIMEOUT   = vm1_bus_pkg::C_BUS_TIMEOUT_DEF,
  parameter int unsigned OFFER_TIMEOUT = vm1_bus_pkg::C_OFFER_TIMEOUT_DEF,
  parameter int unsigned CPU_GAP       = vm1_bus_pkg::C_CPU_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       cpu_sync,
  input  logic       bus_rply,
  input  logic       dmr_i,
  input  logic       sack_i,
  input  logic       dma_sync,
  output logic       dmgo_o,
  output logic       cpu_hold_o,
  output logic       dma_owner_o,
  output logic       cpu_err_o,
  output logic       dma_err_o,
  output logic [2:0] state_o
);

  import vm1_bus_pkg::*;

  localparam int unsigned OW = cnt_width(OFFER_TIMEOUT);
  localparam int unsigned GW = cnt_width(CPU_GAP);

  // Offer counter value on the last tick DMGO may remain asserted.
  localparam logic [OW-1:0] C_OFFER_LAST = OW'((OFFER_TIMEOUT == 0) ? 0 : OFFER_TIMEOUT - 1);
  localparam logic [GW-1:0] C_GAP_LOAD   = GW'(CPU_GAP);

  bus_state_t    r_state;
  bus_state_t    w_next;
  logic [OW-1:0] r_offer_cnt;
  logic [GW-1:0] r_gap;
  logic          w_gap_load;
  logic          w_offer_to;
  logic          w_mon_sync;
  logic          w_wd_pulse;
  logic          r_err_dma;

  assign w_offer_to = (r_offer_cnt == C_OFFER_LAST);

  // State register; async reset drops DMGO and hold at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CPU;
    end else if (ce) begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_next      = r_state;
    w_gap_load  = 1'b0;
    dmgo_o      = 1'b0;
    cpu_hold_o  = 1'b0;
    dma_owner_o = 1'b0;
    case (r_state)
      S_CPU: begin
        // A stray SACK with no offer outstanding is deliberately ignored here.
        if (dmr_i && (r_gap == '0)) begin
          w_next = cpu_sync ? S_DRAIN : S_OFFER;
        end
      end
      S_DRAIN: begin
        cpu_hold_o = 1'b1;
        if (!dmr_i) begin
          w_next = S_CPU;
        end else if (!cpu_sync) begin
          w_next = S_OFFER;
        end
      end
      S_OFFER: begin
        cpu_hold_o = 1'b1;
        dmgo_o     = 1'b1;
        // SACK takes priority over a coincident offer timeout.
        if (sack_i) begin
          w_next = S_DMA;
        end else if (!dmr_i || w_offer_to) begin
          w_next     = S_CPU;
          w_gap_load = 1'b1;
        end
      end
      S_DMA: begin
        cpu_hold_o  = 1'b1;
        dma_owner_o = 1'b1;
        // The DMA master keeps the bus until both SACK and its SYNC are gone.
        if (!sack_i && !dma_sync) begin
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_gap_load = 1'b1;
        w_next     = S_CPU;
      end
      default: begin
        w_next = S_CPU;
      end
    endcase
  end

  // Offer counter: runs only while DMGO is up, restarts on every new offer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_offer_cnt <= '0;
    end else if (r_state != S_OFFER) begin
      r_offer_cnt <= '0;
    end else if (ce && !w_offer_to) begin
      r_offer_cnt <= r_offer_cnt + OW'(1);
    end
  end

  // CPU window counter: suppresses DMR arbitration while nonzero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap <= '0;
    end else if (ce) begin
      if (w_gap_load) begin
        r_gap <= C_GAP_LOAD;
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GW'(1);
      end
    end
  end

  assign w_mon_sync = dma_owner_o ? dma_sync : cpu_sync;

  bus_watchdog #(
    .BUS_TIMEOUT (BUS_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .sync    (w_mon_sync),
    .rply    (bus_rply),
    .timeout (w_wd_pulse)
  );

  // Owner captured on the same ce edge the watchdog registers its pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_dma <= 1'b0;
    end else if (ce) begin
      r_err_dma <= dma_owner_o;
    end
  end

  assign cpu_err_o = w_wd_pulse & ~r_err_dma;
  assign dma_err_o = w_wd_pulse &  r_err_dma;
  assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_qbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qbus_arbiter
// Purpose  : Self-checking bench for qbus_arbiter: table-driven handshake
//            vectors plus directed offer-timeout, watchdog and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qbus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic       cpu_sync;
  logic       bus_rply;
  logic       dmr_i;
  logic       sack_i;
  logic       dma_sync;
  logic       dmgo_o;
  logic       cpu_hold_o;
  logic       dma_owner_o;
  logic       cpu_err_o;
  logic       dma_err_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  // Inputs {ce,cpu_sync,rply,dmr,sack,dma_sync}; expected {state, dmgo,hold,owner,cpu_err,dma_err} after one clock.
  typedef struct packed {
    logic [5:0] in;
    logic [2:0] st;
    logic [4:0] out;
  } vec_t;

  vec_t vecs[$];

  qbus_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .cpu_sync    (cpu_sync),
    .bus_rply    (bus_rply),
    .dmr_i       (dmr_i),
    .sack_i      (sack_i),
    .dma_sync    (dma_sync),
    .dmgo_o      (dmgo_o),
    .cpu_hold_o  (cpu_hold_o),
    .dma_owner_o (dma_owner_o),
    .cpu_err_o   (cpu_err_o),
    .dma_err_o   (dma_err_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("FAIL sim_timeout: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [5:0] in);
    {ce, cpu_sync, bus_rply, dmr_i, sack_i, dma_sync} = in;
  endtask

  task automatic add(input logic [5:0] in, input logic [2:0] st, input logic [4:0] out);
    vec_t v;
    v.in  = in;
    v.st  = st;
    v.out = out;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] outs();
    return {state_o, dmgo_o, cpu_hold_o, dma_owner_o, cpu_err_o, dma_err_o};
  endfunction

  initial begin
    int cnt;
    int pulses;
    int at;
    int other;

    //   ce cs rp dmr sk ds   st     go hd own ce de
    add(6'b1_0_0_1_0_0, 3'd2, 5'b1_1_0_0_0); // idle bus: DMGO on first tick
    add(6'b1_0_0_1_1_0, 3'd3, 5'b0_1_1_0_0); // SACK: DMA owns, DMGO drops
    add(6'b1_0_0_0_1_0, 3'd3, 5'b0_1_1_0_0);
    add(6'b1_0_0_0_0_1, 3'd3, 5'b0_1_1_0_0); // SACK gone but DMA SYNC still up
    add(6'b1_0_0_0_0_0, 3'd4, 5'b0_0_0_0_0); // release
    add(6'b1_0_0_1_0_0, 3'd0, 5'b0_0_0_0_0); // back to CPU, gap loaded
    add(6'b1_0_0_1_0_0, 3'd0, 5'b0_0_0_0_0); // gap 2: DMR ignored
    add(6'b1_0_0_1_0_0, 3'd0, 5'b0_0_0_0_0); // gap 1: DMR ignored
    add(6'b1_0_0_1_0_0, 3'd2, 5'b1_1_0_0_0); // gap expired: offer
    add(6'b1_0_0_0_0_0, 3'd0, 5'b0_0_0_0_0); // DMR withdrawn during offer
    add(6'b1_0_0_0_0_0, 3'd0, 5'b0_0_0_0_0);
    add(6'b1_0_0_0_0_0, 3'd0, 5'b0_0_0_0_0);
    add(6'b1_1_0_0_0_0, 3'd0, 5'b0_0_0_0_0); // CPU cycle starts
    add(6'b1_1_0_1_0_0, 3'd1, 5'b0_1_0_0_0); // DMR during CPU cycle: drain
    add(6'b1_1_0_1_0_0, 3'd1, 5'b0_1_0_0_0);
    add(6'b1_1_0_1_0_0, 3'd1, 5'b0_1_0_0_0);
    add(6'b1_1_0_1_0_0, 3'd1, 5'b0_1_0_0_0);
    add(6'b1_0_0_1_0_0, 3'd2, 5'b1_1_0_0_0); // CPU SYNC fell: offer
    add(6'b1_0_0_1_1_0, 3'd3, 5'b0_1_1_0_0);
    add(6'b1_0_0_0_0_0, 3'd4, 5'b0_0_0_0_0);
    add(6'b1_0_0_0_0_0, 3'd0, 5'b0_0_0_0_0);
    add(6'b1_0_0_0_0_0, 3'd0, 5'b0_0_0_0_0);
    add(6'b1_0_0_0_0_0, 3'd0, 5'b0_0_0_0_0);
    add(6'b1_1_0_1_0_0, 3'd1, 5'b0_1_0_0_0); // drain again
    add(6'b1_1_0_0_0_0, 3'd0, 5'b0_0_0_0_0); // DMR drops in drain: abandon
    add(6'b1_0_0_0_1_0, 3'd0, 5'b0_0_0_0_0); // stray SACK ignored
    add(6'b0_0_0_1_0_0, 3'd0, 5'b0_0_0_0_0); // ce=0: frozen
    add(6'b1_0_0_1_0_0, 3'd2, 5'b1_1_0_0_0);
    add(6'b0_0_0_1_1_0, 3'd2, 5'b1_1_0_0_0); // ce=0: SACK not taken
    add(6'b1_0_0_1_1_0, 3'd3, 5'b0_1_1_0_0);
    add(6'b1_0_0_0_0_0, 3'd4, 5'b0_0_0_0_0);
    add(6'b1_0_0_0_0_0, 3'd0, 5'b0_0_0_0_0);

    // Reset state
    reset_n = 1'b0;
    apply(6'b1_0_0_0_0_0);
    repeat (2) @(posedge clk);
    #3;
    chk("reset_in", {24'd0, outs()}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("reset_out", {24'd0, outs()}, 32'd0);

    // Table-driven handshake vectors
    foreach (vecs[i]) begin
      apply(vecs[i].in);
      tick();
      chk($sformatf("vec%0d", i), {24'd0, outs()}, {24'd0, vecs[i].st, vecs[i].out});
    end

    // Offer timeout, then CPU window, then re-offer
    apply(6'b1_0_0_0_0_0);
    repeat (3) tick();
    dmr_i = 1'b1;
    tick();
    chk("offer_rise", {31'd0, dmgo_o}, 32'd1);
    cnt = 0;
    while (dmgo_o && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("offer_len", cnt, 32'd15);
    chk("offer_to_state", {29'd0, state_o}, 32'd0);
    chk("offer_to_hold", {31'd0, cpu_hold_o}, 32'd0);
    tick();
    chk("gap_tick1", {29'd0, state_o}, 32'd0);
    tick();
    chk("gap_tick2", {29'd0, state_o}, 32'd0);
    tick();
    chk("reoffer", {24'd0, outs()}, {24'd0, 3'd2, 5'b1_1_0_0_0});
    dmr_i = 1'b0;
    tick();

    // SACK arriving on the same tick the offer would time out
    repeat (3) tick();
    dmr_i = 1'b1;
    tick();
    repeat (14) tick();
    chk("pre_timeout_state", {29'd0, state_o}, 32'd2);
    sack_i = 1'b1;
    tick();
    chk("sack_beats_timeout", {24'd0, outs()}, {24'd0, 3'd3, 5'b0_1_1_0_0});
    sack_i = 1'b0;
    dmr_i  = 1'b0;
    tick();
    tick();

    // CPU watchdog: one pulse at tick 63, then silent while SYNC stays high
    cpu_sync = 1'b1;
    pulses = 0; at = -1; other = 0;
    for (int k = 1; k <= 75; k++) begin
      tick();
      if (cpu_err_o) begin
        pulses++;
        if (at < 0) at = k;
      end
      if (dma_err_o) other++;
    end
    chk("cpu_err_count", pulses, 32'd1);
    chk("cpu_err_tick", at, 32'd63);
    chk("cpu_err_no_dma", other, 32'd0);
    cpu_sync = 1'b0;
    tick();

    // RPLY part-way through clears the count
    cpu_sync = 1'b1;
    other = 0;
    repeat (40) begin
      tick();
      if (cpu_err_o || dma_err_o) other++;
    end
    bus_rply = 1'b1;
    tick();
    bus_rply = 1'b0;
    repeat (40) begin
      tick();
      if (cpu_err_o || dma_err_o) other++;
    end
    chk("rply_clears", other, 32'd0);
    cpu_sync = 1'b0;
    tick();

    // DMA watchdog: CPU SYNC is not monitored while DMA owns the bus
    dmr_i = 1'b1;
    tick();
    sack_i = 1'b1;
    tick();
    chk("dma_owner", {31'd0, dma_owner_o}, 32'd1);
    dmr_i = 1'b0;
    cpu_sync = 1'b1;
    other = 0;
    repeat (70) begin
      tick();
      if (cpu_err_o || dma_err_o) other++;
    end
    chk("cpu_sync_masked", other, 32'd0);
    cpu_sync = 1'b0;
    dma_sync = 1'b1;
    pulses = 0; at = -1; other = 0;
    for (int k = 1; k <= 75; k++) begin
      tick();
      if (dma_err_o) begin
        pulses++;
        if (at < 0) at = k;
      end
      if (cpu_err_o) other++;
    end
    chk("dma_err_count", pulses, 32'd1);
    chk("dma_err_tick", at, 32'd63);
    chk("dma_err_no_cpu", other, 32'd0);

    // Asynchronous reset while DMA holds the bus with SYNC up
    chk("pre_reset_state", {29'd0, state_o}, 32'd3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset", {24'd0, outs()}, 32'd0);
    sack_i   = 1'b0;
    dma_sync = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    dmr_i = 1'b1;
    tick();
    chk("post_reset_offer", {24'd0, outs()}, {24'd0, 3'd2, 5'b1_1_0_0_0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
